// File: rtl/class_hvec_streamer_pkg.sv
// Shared definitions for the class hypervector streamer: default sizes,
// the width helper and the FSM state type.
package class_hvec_streamer_pkg;

  localparam int FRAME_W_DEF     = 64;
  localparam int NUM_CLASSES_DEF = 8;
  localparam int NUM_FRAMES_DEF  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Index width for n entries; a single entry still needs one bit of port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/class_hvec_store.sv
// Class hypervector storage: NUM_CLASSES x NUM_FRAMES frames with one
// synchronous write port and one combinational read port.
module class_hvec_store
  import class_hvec_streamer_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int CLASS_ID_W  = clog2_min1(NUM_CLASSES),
  parameter int FRAME_IDX_W = clog2_min1(NUM_FRAMES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [CLASS_ID_W-1:0]  wr_class_id,
  input  logic [FRAME_IDX_W-1:0] wr_frame_idx,
  input  logic [FRAME_W-1:0]     wr_data,
  input  logic [CLASS_ID_W-1:0]  rd_class_id,
  input  logic [FRAME_IDX_W-1:0] rd_frame_idx,
  output logic [FRAME_W-1:0]     rd_data
);

  logic [FRAME_W-1:0] mem_q [NUM_CLASSES][NUM_FRAMES];
  logic               wr_in_range;
  logic               rd_in_range;

  assign wr_in_range = (int'(wr_class_id) < NUM_CLASSES) && (int'(wr_frame_idx) < NUM_FRAMES);
  assign rd_in_range = (int'(rd_class_id) < NUM_CLASSES) && (int'(rd_frame_idx) < NUM_FRAMES);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is cleared on reset because a stream after reset must
      // return all-zero frames; this keeps it in flops rather than a RAM macro.
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
          mem_q[c][f] <= '0;
        end
      end
    end else if (wr_en && wr_in_range) begin
      mem_q[wr_class_id][wr_frame_idx] <= wr_data;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem_q[rd_class_id][rd_frame_idx];
    end
  end

endmodule

// File: rtl/class_hvec_streamer.sv
// Streams the NUM_FRAMES frames of a requested class hypervector over a
// valid/ready interface; storage is updated through a separate write port.
module class_hvec_streamer
  import class_hvec_streamer_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int CLASS_ID_W  = clog2_min1(NUM_CLASSES),
  parameter int FRAME_IDX_W = clog2_min1(NUM_FRAMES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [CLASS_ID_W-1:0]  wr_class_id,
  input  logic [FRAME_IDX_W-1:0] wr_frame_idx,
  input  logic [FRAME_W-1:0]     wr_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CLASS_ID_W-1:0]  req_class_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAME_W-1:0]     out_data,
  output logic [FRAME_IDX_W-1:0] out_frame_idx,
  output logic                   out_last,
  output logic                   err
);

  state_e                 state_q;
  logic [CLASS_ID_W-1:0]  class_q;
  logic [FRAME_IDX_W-1:0] frame_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   err_q;
  logic [FRAME_W-1:0]     out_data_q;

  logic                   req_fire;
  logic                   req_class_ok;
  logic [FRAME_IDX_W-1:0] frame_nxt;
  logic [CLASS_ID_W-1:0]  rd_class;
  logic [FRAME_IDX_W-1:0] rd_frame;
  logic [FRAME_W-1:0]     store_data;
  logic [FRAME_W-1:0]     load_data;

  assign req_ready    = (state_q == IDLE) && !rst;
  assign req_fire     = req_valid && req_ready;
  assign req_class_ok = int'(req_class_id) < NUM_CLASSES;
  assign frame_nxt    = frame_q + FRAME_IDX_W'(1);

  // Address of the frame that would be presented at the next edge.
  always_comb begin
    rd_class = class_q;
    rd_frame = frame_nxt;
    if (state_q == IDLE) begin
      rd_class = req_class_id;
      rd_frame = '0;
    end
  end

  // A write landing on the same edge the frame is loaded is forwarded,
  // so the presented frame always reflects every completed write.
  assign load_data = (wr_en && (wr_class_id == rd_class) && (wr_frame_idx == rd_frame))
                     ? wr_data : store_data;

  class_hvec_store #(
    .FRAME_W     (FRAME_W),
    .NUM_CLASSES (NUM_CLASSES),
    .NUM_FRAMES  (NUM_FRAMES),
    .CLASS_ID_W  (CLASS_ID_W),
    .FRAME_IDX_W (FRAME_IDX_W)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_class_id  (wr_class_id),
    .wr_frame_idx (wr_frame_idx),
    .wr_data      (wr_data),
    .rd_class_id  (rd_class),
    .rd_frame_idx (rd_frame),
    .rd_data      (store_data)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      class_q     <= '0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            if (req_class_ok) begin
              state_q     <= STREAM;
              class_q     <= req_class_id;
              frame_q     <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= load_data;
              out_last_q  <= (NUM_FRAMES == 1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              frame_q    <= frame_nxt;
              out_data_q <= load_data;
              out_last_q <= (int'(frame_nxt) == NUM_FRAMES - 1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_frame_idx = frame_q;
  assign out_last      = out_last_q;
  assign err           = err_q;

endmodule

// File: tb/tb_class_hvec_streamer.sv
// Self-checking bench for class_hvec_streamer: directed scenarios followed by
// a random phase, all compared against a frame-level reference model.
module tb_class_hvec_streamer;

  localparam int FW  = 64;
  localparam int NC  = 6;
  localparam int NF  = 3;
  localparam int CW  = 3;
  localparam int FIW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [CW-1:0]  wr_class_id;
  logic [FIW-1:0] wr_frame_idx;
  logic [FW-1:0]  wr_data;
  logic           req_valid;
  logic           req_ready;
  logic [CW-1:0]  req_class_id;
  logic           out_valid;
  logic           out_ready;
  logic [FW-1:0]  out_data;
  logic [FIW-1:0] out_frame_idx;
  logic           out_last;
  logic           err;

  // Single-frame instance for the NUM_FRAMES=1 corner.
  logic       s_wr_en;
  logic [0:0] s_wr_class_id;
  logic [0:0] s_wr_frame_idx;
  logic [7:0] s_wr_data;
  logic       s_req_valid;
  logic       s_req_ready;
  logic [0:0] s_req_class_id;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out_data;
  logic [0:0] s_out_frame_idx;
  logic       s_out_last;
  logic       s_err;

  always #5 clk = ~clk;

  class_hvec_streamer #(
    .FRAME_W (FW), .NUM_CLASSES (NC), .NUM_FRAMES (NF)
  ) dut (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_class_id (wr_class_id), .wr_frame_idx (wr_frame_idx), .wr_data (wr_data),
    .req_valid (req_valid), .req_ready (req_ready), .req_class_id (req_class_id),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_frame_idx (out_frame_idx), .out_last (out_last), .err (err)
  );

  class_hvec_streamer #(
    .FRAME_W (8), .NUM_CLASSES (2), .NUM_FRAMES (1)
  ) dut_one (
    .clk (clk), .rst (rst),
    .wr_en (s_wr_en), .wr_class_id (s_wr_class_id), .wr_frame_idx (s_wr_frame_idx), .wr_data (s_wr_data),
    .req_valid (s_req_valid), .req_ready (s_req_ready), .req_class_id (s_req_class_id),
    .out_valid (s_out_valid), .out_ready (s_out_ready), .out_data (s_out_data),
    .out_frame_idx (s_out_frame_idx), .out_last (s_out_last), .err (s_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: stored frames plus the frame currently on offer.
  logic [FW-1:0] ref_mem [NC][NF];
  bit            m_busy;
  bit            m_err;
  int            m_cls;
  int            m_idx;
  logic [FW-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge from the currently driven inputs, clock the
  // DUT, then compare every observable output.
  task automatic cycle();
    bit was_rst;
    bit accept;
    bit advance;
    was_rst = rst;
    if (rst) begin
      for (int c = 0; c < NC; c++)
        for (int f = 0; f < NF; f++)
          ref_mem[c][f] = '0;
      m_busy = 0;
      m_err  = 0;
      m_idx  = 0;
      m_data = '0;
    end else begin
      accept  = req_valid && !m_busy;
      advance = m_busy && out_ready;
      m_err   = 0;
      if (wr_en && int'(wr_class_id) < NC && int'(wr_frame_idx) < NF)
        ref_mem[int'(wr_class_id)][int'(wr_frame_idx)] = wr_data;
      if (advance) begin
        if (m_idx == NF - 1) begin
          m_busy = 0;
        end else begin
          m_idx++;
          m_data = ref_mem[m_cls][m_idx];
        end
      end else if (accept) begin
        if (int'(req_class_id) < NC) begin
          m_busy = 1;
          m_cls  = int'(req_class_id);
          m_idx  = 0;
          m_data = ref_mem[m_cls][0];
        end else begin
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_busy);
    chk("req_ready", req_ready, !m_busy && !rst);
    chk("err", err, m_err);
    if (m_busy) begin
      chk("out_data", out_data, m_data);
      chk("out_frame_idx", out_frame_idx, m_idx);
      chk("out_last", out_last, m_idx == NF - 1);
    end
    if (was_rst) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_frame_idx", out_frame_idx, 0);
      chk("rst_out_last", out_last, 0);
    end
  endtask

  task automatic wr(input int c, input int f, input logic [FW-1:0] d);
    wr_en        = 1'b1;
    wr_class_id  = CW'(c);
    wr_frame_idx = FIW'(f);
    wr_data      = d;
    cycle();
    wr_en = 1'b0;
  endtask

  function automatic logic [FW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] d1;
    logic [7:0]    sd;
    int            gap;
    int            n;

    rst = 1'b1;  wr_en = 1'b0; wr_class_id = '0; wr_frame_idx = '0; wr_data = '0;
    req_valid = 1'b0; req_class_id = '0; out_ready = 1'b0;
    s_wr_en = 1'b0; s_wr_class_id = '0; s_wr_frame_idx = '0; s_wr_data = '0;
    s_req_valid = 1'b0; s_req_class_id = '0; s_out_ready = 1'b0;

    // Reset values
    cycle();
    cycle();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", req_ready, 1);

    // Basic stream of class 2 with out_ready held high
    wr(2, 0, 64'h1111_1111_1111_1111);
    wr(2, 1, 64'h2222_2222_2222_2222);
    wr(2, 2, 64'h3333_3333_3333_3333);
    req_valid = 1'b1; req_class_id = 3'd2; out_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("c2_idx0", out_frame_idx, 0);
    chk("c2_data0", out_data, 64'h1111_1111_1111_1111);
    chk("c2_last0", out_last, 0);
    cycle();
    chk("c2_idx1", out_frame_idx, 1);
    chk("c2_data1", out_data, 64'h2222_2222_2222_2222);
    cycle();
    chk("c2_idx2", out_frame_idx, 2);
    chk("c2_data2", out_data, 64'h3333_3333_3333_3333);
    chk("c2_last2", out_last, 1);
    cycle();
    chk("c2_done_valid", out_valid, 0);
    chk("c2_done_ready", req_ready, 1);

    // Stall on frame 1 of class 5 with writes behind the presented frame
    wr(5, 0, rnd64());
    d1 = rnd64();
    wr(5, 1, d1);
    wr(5, 2, rnd64());
    req_valid = 1'b1; req_class_id = 3'd5; out_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("c5_stall_idx", out_frame_idx, 1);
    out_ready = 1'b0;
    wr(5, 1, 64'hAAAA_AAAA_AAAA_AAAA);
    wr(5, 2, 64'hBBBB_BBBB_BBBB_BBBB);
    cycle();
    cycle();
    chk("c5_hold_data", out_data, d1);
    chk("c5_hold_idx", out_frame_idx, 1);
    chk("c5_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    cycle();
    chk("c5_resume_idx", out_frame_idx, 2);
    chk("c5_resume_data", out_data, 64'hBBBB_BBBB_BBBB_BBBB);
    cycle();
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("c5_repeat_data1", out_data, 64'hAAAA_AAAA_AAAA_AAAA);
    cycle();
    cycle();

    // Out-of-range class request
    req_valid = 1'b1; req_class_id = 3'd7;
    cycle();
    req_valid = 1'b0;
    chk("bad_class_err", err, 1);
    chk("bad_class_valid", out_valid, 0);
    chk("bad_class_ready", req_ready, 1);
    cycle();
    chk("bad_class_err_pulse", err, 0);
    chk("bad_class_still_idle", out_valid, 0);

    // Reset mid-stream, with a write in the reset cycle
    req_valid = 1'b1; req_class_id = 3'd2;
    cycle();
    req_valid = 1'b0;
    cycle();
    rst = 1'b1;
    wr_en = 1'b1; wr_class_id = 3'd3; wr_frame_idx = 2'd0; wr_data = rnd64();
    cycle();
    chk("midrst_valid", out_valid, 0);
    rst = 1'b0; wr_en = 1'b0;
    cycle();
    req_valid = 1'b1; req_class_id = 3'd2;
    cycle();
    req_valid = 1'b0;
    chk("post_rst_data0", out_data, 0);
    cycle();
    cycle();
    cycle();
    req_valid = 1'b1; req_class_id = 3'd3;
    cycle();
    req_valid = 1'b0;
    chk("dropped_write_data", out_data, 0);
    cycle();
    cycle();
    cycle();

    // Back-to-back requests: class 0 then class 3
    wr(0, 2, rnd64());
    wr(3, 0, rnd64());
    req_valid = 1'b1; req_class_id = 3'd0; out_ready = 1'b1;
    cycle();
    req_class_id = 3'd3;
    cycle();
    cycle();
    chk("b2b_last0", out_last, 1);
    gap = 0;
    n   = 0;
    do begin
      cycle();
      n++;
      if (!out_valid) gap++;
    end while (!out_valid && n < 8);
    req_valid = 1'b0;
    chk("b2b_gap", gap, 1);
    chk("b2b_next_idx", out_frame_idx, 0);
    cycle();
    cycle();
    cycle();

    // Single-frame instance: every frame is last
    sd = 8'($urandom);
    s_wr_en = 1'b1; s_wr_class_id = 1'b1; s_wr_frame_idx = 1'b0; s_wr_data = sd;
    cycle();
    s_wr_en = 1'b0;
    s_req_valid = 1'b1; s_req_class_id = 1'b1; s_out_ready = 1'b1;
    cycle();
    s_req_valid = 1'b0;
    chk("nf1_valid", s_out_valid, 1);
    chk("nf1_last", s_out_last, 1);
    chk("nf1_idx", s_out_frame_idx, 0);
    chk("nf1_data", s_out_data, sd);
    cycle();
    chk("nf1_done_valid", s_out_valid, 0);
    chk("nf1_done_ready", s_req_ready, 1);

    // Random phase against the model
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      wr_en        = ($urandom_range(0, 2) == 0);
      wr_class_id  = CW'($urandom_range(0, 7));
      wr_frame_idx = FIW'($urandom_range(0, 3));
      wr_data      = rnd64();
      req_valid    = ($urandom_range(0, 3) == 0);
      req_class_id = CW'($urandom_range(0, 7));
      out_ready    = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Drain
    rst = 1'b0; wr_en = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      cycle();
      n++;
    end
    chk("drain_idle_within_budget", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/class_hvec_streamer.md
CLASS_HVEC_STREAMER -- requirements
Module: class_hvec_streamer

Interface
REQ-001 SHALL have parameter FRAME_W, default 64: bits per hypervector frame.
REQ-002 SHALL have parameter NUM_CLASSES, default 8: number of stored class hypervectors.
REQ-003 SHALL have parameter NUM_FRAMES, default 3: frames per class hypervector.
REQ-004 SHALL have derived parameter CLASS_ID_W, default clog2(NUM_CLASSES) with a minimum of 1: class id width.
REQ-005 SHALL have derived parameter FRAME_IDX_W, default clog2(NUM_FRAMES) with a minimum of 1: frame index width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_en  in  1  write strobe for one frame (load/training update).
REQ-009 wr_class_id  in  CLASS_ID_W  target class of the write.
REQ-010 wr_frame_idx  in  FRAME_IDX_W  target frame of the write.
REQ-011 wr_data  in  FRAME_W  frame data to store.
REQ-012 req_valid  in  1  stream request valid.
REQ-013 req_ready  out  1  block can accept a request.
REQ-014 req_class_id  in  CLASS_ID_W  class to stream.
REQ-015 out_valid  out  1  out_data holds a valid frame.
REQ-016 out_ready  in  1  consumer accepts the frame.
REQ-017 out_data  out  FRAME_W  current frame.
REQ-018 out_frame_idx  out  FRAME_IDX_W  index of the current frame.
REQ-019 out_last  out  1  current frame is frame NUM_FRAMES-1.
REQ-020 err  out  1  one-cycle pulse when a request names a class >= NUM_CLASSES.

Function
REQ-021 Storage SHALL be an array of NUM_CLASSES x NUM_FRAMES frames, each FRAME_W bits.
REQ-022 A write with wr_en=1 SHALL update storage at the next edge; a write with an out-of-range class or frame SHALL be ignored.
REQ-023 The FSM SHALL have exactly two states, IDLE and STREAM; req_ready SHALL equal 1 only in IDLE.
REQ-024 In IDLE, a request handshake (req_valid & req_ready) with a valid class SHALL latch the class id, clear the frame counter and move to STREAM.
REQ-025 out_valid SHALL rise in the cycle after the request handshake, with out_frame_idx=0 (latency 1 cycle).
REQ-026 out_data SHALL be loaded from storage when a frame is presented and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 A write that hits the frame currently presented SHALL NOT change out_data; it SHALL take effect on later reads.
REQ-028 A write to a frame not yet presented SHALL be visible when that frame is presented.
REQ-029 When an output handshake occurs on a frame that is not last, the counter SHALL increment and the next frame SHALL be presented in the next cycle with no bubble.
REQ-030 When an output handshake occurs with out_last=1, the FSM SHALL return to IDLE, drive out_valid=0 in the next cycle and raise req_ready in that same cycle.
REQ-031 A request handshake with class id >= NUM_CLASSES SHALL pulse err for one cycle, SHALL stream nothing and SHALL keep the FSM in IDLE.
REQ-032 When NUM_FRAMES=1, every presented frame SHALL have out_last=1.

Reset
REQ-033 While rst=1 the block SHALL enter IDLE, clear all storage to 0 and drive out_valid=0, out_data=0, out_frame_idx=0, out_last=0, err=0 and req_ready=0.
REQ-034 req_ready SHALL be 1 in the first cycle after rst is released.
REQ-035 Reset asserted mid-stream SHALL abort the stream with no further frames; writes in the same cycle as rst SHALL be dropped.

Structure
REQ-036 A shared package SHALL hold the default FRAME_W, NUM_CLASSES and NUM_FRAMES values, the clog2-with-min-1 helper and the FSM state enum.
REQ-037 The storage array, with its synchronous write and combinational read, SHALL be one sub-module named class_hvec_store; the FSM and handshake logic SHALL be in the top module.

Verification
REQ-038 After reset, write class 2 frames 0..2 with 0x1111..., 0x2222..., 0x3333..., then request class 2 with out_ready held at 1 -> three consecutive frames with idx 0,1,2 and the written data, out_last only on idx 2, and req_ready=1 in the cycle after the last handshake.
REQ-039 Request class 5 and hold out_ready=0 for 4 cycles on frame 1 -> out_data, out_frame_idx and out_valid stay stable; the stream resumes at frame 2 once out_ready=1.
REQ-040 While frame 1 of class 5 is stalled, write class 5 frame 1 = 0xAAAA... and frame 2 = 0xBBBB... -> out_data keeps its old value; the next frame presented is 0xBBBB...; a repeat request then returns 0xAAAA... for frame 1.
REQ-041 With NUM_CLASSES=6, request class 7 -> one err pulse, out_valid stays 0, req_ready stays 1.
REQ-042 Assert rst during frame 1 of a stream -> out_valid=0 the next cycle; a later request for the same class returns all-zero frames.
REQ-043 Back-to-back requests (req_valid held at 1, classes 0 then 3) -> exactly one idle cycle between the last frame of class 0 and frame 0 of class 3.
